// File: rtl/rename_pkg.sv
// rename_pkg: shared sizes, packet types and pointer helper for the rename stage
// Exports NUM_AREG, NUM_PREG, PREG_W, FREE_INIT, decode_data, rename_data, ptr_inc.
package rename_pkg;
  localparam int NUM_AREG = 32;
  localparam int NUM_PREG = 128;
  localparam int PREG_W = $clog2(NUM_PREG);
  localparam int FREE_INIT = NUM_PREG - NUM_AREG;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
  } decode_data;
  typedef struct packed {
    decode_data        dec;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] old_prd;
  } rename_data;
  function automatic logic [PREG_W-1:0] ptr_inc(input logic [PREG_W-1:0] p);
    return p == PREG_W'(NUM_PREG - 1) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/rename_free_list.sv
// free_list: circular FIFO of free physical registers
// Ports: clk, reset (async, active-high), pop/pop_data (head), push/push_data (tail), empty;
// restore (only with RENAME_FLUSH_EN) rewinds head to the committed head.
module free_list
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              pop,
  input  logic              push,
  input  logic [PREG_W-1:0] push_data,
`ifdef RENAME_FLUSH_EN
  input  logic              restore,
`endif
  output logic [PREG_W-1:0] pop_data,
  output logic              empty
);
  logic [PREG_W-1:0] fifo [NUM_PREG];
  logic [PREG_W-1:0] head, tail, tail_n;
  logic [PREG_W:0]   count;
`ifdef RENAME_FLUSH_EN
  logic [PREG_W-1:0] chead, chead_n;
  // every committed writer consumed exactly one pop, so the committed head moves with each push
  assign chead_n = push ? ptr_inc(chead) : chead;
`endif
  assign tail_n = push ? ptr_inc(tail) : tail;
  assign pop_data = fifo[head];
  assign empty = count == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_PREG; i++) fifo[i] <= i < FREE_INIT ? PREG_W'(i + NUM_AREG) : '0;
      head <= '0;
      tail <= PREG_W'(FREE_INIT);
      count <= (PREG_W+1)'(FREE_INIT);
`ifdef RENAME_FLUSH_EN
      chead <= '0;
`endif
    end else begin
      if (push) fifo[tail] <= push_data;
      tail <= tail_n;
`ifdef RENAME_FLUSH_EN
      chead <= chead_n;
      if (restore) begin
        head <= chead_n;
        count <= tail_n >= chead_n ? {1'b0, tail_n - chead_n} : (PREG_W+1)'(NUM_PREG) + tail_n - chead_n;
      end else
`endif
      begin
        if (pop) head <= ptr_inc(head);
        count <= count + (PREG_W+1)'(push) - (PREG_W+1)'(pop);
      end
    end
  assert property (@(posedge clk) disable iff (reset) !(push && count == (PREG_W+1)'(NUM_PREG)));
endmodule

// File: rtl/rename.sv
// rename: maps architectural to physical registers and registers a rename_data packet for dispatch
// Ports: clk, reset (async, active-high); valid_in/ready_in/data_in from decode;
// valid_out/ready_out/data_out to dispatch; commit_* returns freed pregs;
// flush exists only when RENAME_FLUSH_EN is defined and restores the committed map.
module rename
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  decode_data        data_in,
  output logic              valid_out,
  input  logic              ready_out,
  output rename_data        data_out,
  input  logic              commit_valid,
  input  logic              commit_we,
  input  logic [4:0]        commit_areg,
  input  logic [PREG_W-1:0] commit_prd,
  input  logic [PREG_W-1:0] commit_old_prd
`ifdef RENAME_FLUSH_EN
  ,
  input  logic              flush
`endif
);
  logic [PREG_W-1:0] map [NUM_AREG];
  logic [PREG_W-1:0] fl_data;
  logic empty, kill, accept, alloc, push;
`ifdef RENAME_FLUSH_EN
  logic [PREG_W-1:0] cmap [NUM_AREG];
  assign kill = flush;
`else
  logic unused_commit;
  assign unused_commit = ^{commit_areg, commit_prd};
  assign kill = 1'b0;
`endif
  // the free-list check ignores rd_we so ready_in never depends on data_in
  assign ready_in = (!valid_out || ready_out) && !empty;
  assign accept = valid_in && ready_in && !kill;
  assign alloc = accept && data_in.rd_we && data_in.rd != 5'd0;
  assign push = commit_valid && commit_we;
  free_list u_free_list (
    .clk(clk),
    .reset(reset),
    .pop(alloc),
    .push(push),
    .push_data(commit_old_prd),
`ifdef RENAME_FLUSH_EN
    .restore(flush),
`endif
    .pop_data(fl_data),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        map[i] <= PREG_W'(i);
`ifdef RENAME_FLUSH_EN
        cmap[i] <= PREG_W'(i);
`endif
      end
      valid_out <= 1'b0;
      data_out <= '0;
    end else begin
`ifdef RENAME_FLUSH_EN
      if (push && commit_areg != 5'd0) cmap[commit_areg] <= commit_prd;
      // a same-cycle commit is folded into the restored map
      if (flush) begin
        for (int i = 0; i < NUM_AREG; i++)
          map[i] <= push && commit_areg == 5'(i) && i != 0 ? commit_prd : cmap[i];
        valid_out <= 1'b0;
      end else
`endif
      begin
        if (alloc) map[data_in.rd] <= fl_data;
        if (accept) begin
          valid_out <= 1'b1;
          data_out <= '{dec: data_in, prs1: map[data_in.rs1], prs2: map[data_in.rs2],
                        prd: alloc ? fl_data : '0, old_prd: alloc ? map[data_in.rd] : '0};
        end else if (ready_out) valid_out <= 1'b0;
      end
    end
endmodule
